// File: rtl/or1200_fwdctrl.sv
// ---------------------------------------------------------------------------
// or1200_fwdctrl -- operand forwarding control for the OR1200 integer pipe.
//
// Tracks the destination register of the instructions currently in ID and EX
// and, for the instruction being decoded, picks each operand source for the
// following cycle: register file, immediate (B only), EX result or WB result.
//
// Optional feature:
//   OR1200_FWDCTRL_LOAD_STALL_EN  When defined, a load in ID whose result is
//     consumed by the next instruction raises load_stall for one cycle and a
//     bubble is pushed into ID. The re-presented consumer then picks the load
//     result up from WB. When undefined, load_stall is tied low and loads are
//     forwarded like any other producer.
//
// Reset is synchronous and active-high; all state updates on rising clk.
// ---------------------------------------------------------------------------
module or1200_fwdctrl #(
  parameter int OR1200_FWD_AW = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_freeze,
  input  logic                     ex_freeze,
  input  logic                     flushpipe,
  input  logic [OR1200_FWD_AW-1:0] dc_rfa_addr,
  input  logic [OR1200_FWD_AW-1:0] dc_rfb_addr,
  input  logic                     dc_rfa_en,
  input  logic                     dc_rfb_en,
  input  logic                     dc_imm,
  input  logic                     dc_rfwb_en,
  input  logic [OR1200_FWD_AW-1:0] dc_rfwb_addr,
  input  logic                     dc_load,
  output logic [1:0]               sel_a,
  output logic [1:0]               sel_b,
  output logic                     ex_rfwb_en,
  output logic [OR1200_FWD_AW-1:0] ex_rfwb_addr,
  output logic                     load_stall
);

  localparam int AW = OR1200_FWD_AW;

  // Operand select encoding seen by the EX operand muxes.
  typedef enum logic [1:0] {
    SEL_RF      = 2'd0,
    SEL_IMM     = 2'd1,
    SEL_EX_FORW = 2'd2,
    SEL_WB_FORW = 2'd3
  } sel_e;

  // Producer sitting in ID (will be in EX when the decoded instruction runs).
  logic          r_id_en;
  logic [AW-1:0] r_id_addr;
  // Producer sitting in EX (will be in WB when the decoded instruction runs).
  logic          r_ex_en;
  logic [AW-1:0] r_ex_addr;
  // Registered operand selects.
  sel_e          r_sel_a;
  sel_e          r_sel_b;

  logic          w_a_id_match;
  logic          w_a_ex_match;
  logic          w_b_id_match;
  logic          w_b_ex_match;
  logic          w_load_stall;
  sel_e          w_sel_a_nxt;
  sel_e          w_sel_b_nxt;

  // A source matches a producer only when both are live, the addresses agree
  // and the address is not r0 (r0 is hard-wired zero, never forwarded).
  function automatic logic fwd_match(
    input logic          src_en,
    input logic [AW-1:0] src_addr,
    input logic          prod_en,
    input logic [AW-1:0] prod_addr
  );
    return src_en && prod_en && (src_addr == prod_addr) && (src_addr != '0);
  endfunction

  assign w_a_id_match = fwd_match(dc_rfa_en, dc_rfa_addr, r_id_en, r_id_addr);
  assign w_a_ex_match = fwd_match(dc_rfa_en, dc_rfa_addr, r_ex_en, r_ex_addr);
  assign w_b_id_match = fwd_match(dc_rfb_en, dc_rfb_addr, r_id_en, r_id_addr);
  assign w_b_ex_match = fwd_match(dc_rfb_en, dc_rfb_addr, r_ex_en, r_ex_addr);

`ifdef OR1200_FWDCTRL_LOAD_STALL_EN
  // Load flag of the producer in ID; only meaningful with load stalls.
  logic r_id_ld;

  // A load result is not available in EX, so a dependent instruction right
  // behind the load must wait one cycle. An immediate B operand never reads
  // the register file, so it cannot create a hazard.
  assign w_load_stall = r_id_ld && (w_a_id_match || (!dc_imm && w_b_id_match));
`else
  logic w_unused_load;

  // Loads are treated as ordinary producers here; the load flag is unused.
  assign w_unused_load = dc_load;
  assign w_load_stall  = 1'b0;
`endif

  assign load_stall = w_load_stall;

  // Next-cycle operand selects: the nearer producer (ID, i.e. EX next cycle)
  // wins over the older one, and an immediate B operand overrides any match.
  // NOTE: every output of an always_comb block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_sel_a_nxt = SEL_RF;
    w_sel_b_nxt = SEL_RF;

    if (w_a_id_match) begin
      w_sel_a_nxt = SEL_EX_FORW;
    end else if (w_a_ex_match) begin
      w_sel_a_nxt = SEL_WB_FORW;
    end

    if (dc_imm) begin
      w_sel_b_nxt = SEL_IMM;
    end else if (w_b_id_match) begin
      w_sel_b_nxt = SEL_EX_FORW;
    end else if (w_b_ex_match) begin
      w_sel_b_nxt = SEL_WB_FORW;
    end
  end

  // ID producer tracking and operand select registers: reset, then flush,
  // then hold on ID freeze, then bubble on a load stall, else normal advance.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_en   <= 1'b0;
      r_id_addr <= '0;
      r_sel_a   <= SEL_RF;
      r_sel_b   <= SEL_RF;
    end else if (flushpipe) begin
      r_id_en   <= 1'b0;
      r_sel_a   <= SEL_RF;
      r_sel_b   <= SEL_RF;
    end else if (!id_freeze) begin
      if (w_load_stall) begin
        r_id_en <= 1'b0;
        r_sel_a <= SEL_RF;
        r_sel_b <= SEL_RF;
      end else begin
        r_id_en   <= dc_rfwb_en;
        r_id_addr <= dc_rfwb_addr;
        r_sel_a   <= w_sel_a_nxt;
        r_sel_b   <= w_sel_b_nxt;
      end
    end
  end

`ifdef OR1200_FWDCTRL_LOAD_STALL_EN
  // Load flag follows the ID producer; cleared by reset, flush and bubbles.
  always_ff @(posedge clk) begin
    if (rst || flushpipe) begin
      r_id_ld <= 1'b0;
    end else if (!id_freeze) begin
      r_id_ld <= w_load_stall ? 1'b0 : dc_load;
    end
  end
`endif

  // EX producer tracking: advance from ID when neither stage is frozen, take a
  // bubble when only ID is frozen, hold on EX freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_en   <= 1'b0;
      r_ex_addr <= '0;
    end else if (flushpipe) begin
      r_ex_en   <= 1'b0;
    end else if (!ex_freeze) begin
      if (id_freeze) begin
        r_ex_en   <= 1'b0;
      end else begin
        r_ex_en   <= r_id_en;
        r_ex_addr <= r_id_addr;
      end
    end
  end

  assign sel_a        = r_sel_a;
  assign sel_b        = r_sel_b;
  assign ex_rfwb_en   = r_ex_en;
  assign ex_rfwb_addr = r_ex_addr;

endmodule

// File: tb/tb_or1200_fwdctrl.sv
// ---------------------------------------------------------------------------
// tb_or1200_fwdctrl -- directed self-checking bench for or1200_fwdctrl.
// Expected values are hand-derived per scenario; load-use expectations follow
// the OR1200_FWDCTRL_LOAD_STALL_EN build option.
// ---------------------------------------------------------------------------
module tb_or1200_fwdctrl;

  localparam int AW = 5;

`ifdef OR1200_FWDCTRL_LOAD_STALL_EN
  localparam logic [31:0] EXP_STALL = 32'd1;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic          clk;
  logic          rst;
  logic          id_freeze;
  logic          ex_freeze;
  logic          flushpipe;
  logic [AW-1:0] dc_rfa_addr;
  logic [AW-1:0] dc_rfb_addr;
  logic          dc_rfa_en;
  logic          dc_rfb_en;
  logic          dc_imm;
  logic          dc_rfwb_en;
  logic [AW-1:0] dc_rfwb_addr;
  logic          dc_load;
  logic [1:0]    sel_a;
  logic [1:0]    sel_b;
  logic          ex_rfwb_en;
  logic [AW-1:0] ex_rfwb_addr;
  logic          load_stall;

  int n_checks;
  int n_fail;

  or1200_fwdctrl #(.OR1200_FWD_AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_freeze    (id_freeze),
    .ex_freeze    (ex_freeze),
    .flushpipe    (flushpipe),
    .dc_rfa_addr  (dc_rfa_addr),
    .dc_rfb_addr  (dc_rfb_addr),
    .dc_rfa_en    (dc_rfa_en),
    .dc_rfb_en    (dc_rfb_en),
    .dc_imm       (dc_imm),
    .dc_rfwb_en   (dc_rfwb_en),
    .dc_rfwb_addr (dc_rfwb_addr),
    .dc_load      (dc_load),
    .sel_a        (sel_a),
    .sel_b        (sel_b),
    .ex_rfwb_en   (ex_rfwb_en),
    .ex_rfwb_addr (ex_rfwb_addr),
    .load_stall   (load_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; sample point sits 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one decoded instruction on the dc_* inputs.
  task automatic present(
    input logic          a_en, input logic [AW-1:0] a,
    input logic          b_en, input logic [AW-1:0] b,
    input logic          imm,
    input logic          wb_en, input logic [AW-1:0] wb,
    input logic          ld
  );
    dc_rfa_en    = a_en;
    dc_rfa_addr  = a;
    dc_rfb_en    = b_en;
    dc_rfb_addr  = b;
    dc_imm       = imm;
    dc_rfwb_en   = wb_en;
    dc_rfwb_addr = wb;
    dc_load      = ld;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    id_freeze = 1'b0;
    ex_freeze = 1'b0;
    flushpipe = 1'b0;
    present(1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 1'b1, 5'd3, 1'b1);

    // Reset: producers presented while rst is high must not be tracked.
    step();
    step();
    check("rst_sel_a", 32'(sel_a), 32'd0);
    check("rst_sel_b", 32'(sel_b), 32'd0);
    check("rst_ex_en", 32'(ex_rfwb_en), 32'd0);
    check("rst_ex_addr", 32'(ex_rfwb_addr), 32'd0);
    check("rst_stall", 32'(load_stall), 32'd0);
    rst = 1'b0;

    // Back-to-back: add r3 ; sub uses r3 ; next op uses r3 and the sub's r8.
    present(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 1'b1, 5'd3, 1'b0);
    step();
    check("add_sel_a", 32'(sel_a), 32'd0);
    present(1'b1, 5'd3, 1'b1, 5'd6, 1'b0, 1'b1, 5'd8, 1'b0);
    step();
    check("sub_sel_a_ex", 32'(sel_a), 32'd2);
    check("sub_sel_b_rf", 32'(sel_b), 32'd0);
    check("sub_ex_en", 32'(ex_rfwb_en), 32'd1);
    check("sub_ex_addr", 32'(ex_rfwb_addr), 32'd3);
    present(1'b1, 5'd3, 1'b1, 5'd8, 1'b0, 1'b1, 5'd11, 1'b0);
    step();
    check("slot2_sel_a_wb", 32'(sel_a), 32'd3);
    check("slot2_sel_b_ex", 32'(sel_b), 32'd2);

    // Double match: r5 in both ID and EX, then r0 producers/sources.
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    step();
    step();
    present(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0);
    step();
    check("dbl_sel_a", 32'(sel_a), 32'd2);
    check("dbl_sel_b", 32'(sel_b), 32'd2);
    present(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
    step();
    check("r0_sel_a", 32'(sel_a), 32'd0);
    check("r0_sel_b", 32'(sel_b), 32'd0);

    // Immediate overrides a B match against ID.
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0);
    step();
    present(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0);
    #1;
    check("imm_no_stall", 32'(load_stall), 32'd0);
    step();
    check("imm_sel_b", 32'(sel_b), 32'd1);
    check("imm_sel_a", 32'(sel_a), 32'd2);

    // Load-use: lwz r7 ; consumer of r7.
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1);
    step();
    present(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0);
    #1;
    check("ld_stall", 32'(load_stall), EXP_STALL);
    step();
`ifdef OR1200_FWDCTRL_LOAD_STALL_EN
    check("ld_bubble_sel_a", 32'(sel_a), 32'd0);
    check("ld_ex_en", 32'(ex_rfwb_en), 32'd1);
    check("ld_ex_addr", 32'(ex_rfwb_addr), 32'd7);
    check("ld_stall_clear", 32'(load_stall), 32'd0);
    step();
    check("ld_re_sel_a", 32'(sel_a), 32'd3);
`else
    check("ld_fwd_sel_a", 32'(sel_a), 32'd2);
    check("ld_nostall", 32'(load_stall), 32'd0);
`endif

    // Freeze: ID frozen two cycles (sel held, EX bubbles), then EX frozen.
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd13, 1'b0);
    step();
    present(1'b1, 5'd13, 1'b0, 5'd0, 1'b0, 1'b1, 5'd14, 1'b0);
    step();
    check("frz_pre_sel_a", 32'(sel_a), 32'd2);
    id_freeze = 1'b1;
    present(1'b1, 5'd13, 1'b0, 5'd0, 1'b0, 1'b1, 5'd30, 1'b0);
    step();
    check("idfrz1_sel_a", 32'(sel_a), 32'd2);
    check("idfrz1_ex_en", 32'(ex_rfwb_en), 32'd0);
    step();
    check("idfrz2_sel_a", 32'(sel_a), 32'd2);
    check("idfrz2_ex_en", 32'(ex_rfwb_en), 32'd0);
    id_freeze = 1'b0;
    present(1'b1, 5'd14, 1'b0, 5'd0, 1'b0, 1'b1, 5'd15, 1'b0);
    step();
    check("idfrz_held_id", 32'(sel_a), 32'd2);
    check("idfrz_ex_addr", 32'(ex_rfwb_addr), 32'd14);
    ex_freeze = 1'b1;
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd16, 1'b0);
    step();
    step();
    check("exfrz_ex_en", 32'(ex_rfwb_en), 32'd1);
    check("exfrz_ex_addr", 32'(ex_rfwb_addr), 32'd14);
    ex_freeze = 1'b0;

    // Flush during a load-use stall, with both stages frozen.
    present(1'b0, 5'd0, 1'b1, 5'd16, 1'b0, 1'b1, 5'd20, 1'b1);
    step();
    check("fl_pre_sel_b", 32'(sel_b), 32'd2);
    present(1'b1, 5'd20, 1'b0, 5'd0, 1'b0, 1'b1, 5'd22, 1'b0);
    flushpipe = 1'b1;
    id_freeze = 1'b1;
    ex_freeze = 1'b1;
    #1;
    check("fl_stall", 32'(load_stall), EXP_STALL);
    step();
    flushpipe = 1'b0;
    id_freeze = 1'b0;
    ex_freeze = 1'b0;
    check("fl_sel_a", 32'(sel_a), 32'd0);
    check("fl_sel_b", 32'(sel_b), 32'd0);
    check("fl_ex_en", 32'(ex_rfwb_en), 32'd0);
    check("fl_stall_clear", 32'(load_stall), 32'd0);

    // Reset during a load-use stall discards all tracked producers.
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd20, 1'b1);
    step();
    present(1'b1, 5'd20, 1'b1, 5'd20, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    check("rs_stall", 32'(load_stall), EXP_STALL);
    rst = 1'b1;
    step();
    check("rs_sel_a", 32'(sel_a), 32'd0);
    check("rs_sel_b", 32'(sel_b), 32'd0);
    check("rs_ex_en", 32'(ex_rfwb_en), 32'd0);
    check("rs_ex_addr", 32'(ex_rfwb_addr), 32'd0);
    check("rs_stall_clear", 32'(load_stall), 32'd0);
    rst = 1'b0;
    step();
    check("rs_after_sel_a", 32'(sel_a), 32'd0);
    check("rs_after_stall", 32'(load_stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/or1200_fwdctrl.md
OR1200_FWDCTRL -- requirements
Module: or1200_fwdctrl

Interface
REQ-001 Parameter: OR1200_FWD_AW, default 5, register address width.
REQ-002 clk  in  1  clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 id_freeze  in  1  ID stage hold.
REQ-005 ex_freeze  in  1  EX stage hold.
REQ-006 flushpipe  in  1  pipeline flush (exception/branch).
REQ-007 dc_rfa_addr, dc_rfb_addr  in  AW each  source A/B addresses of the instruction entering ID.
REQ-008 dc_rfa_en, dc_rfb_en  in  1 each  source A/B read used.
REQ-009 dc_imm  in  1  operand B is the immediate.
REQ-010 dc_rfwb_en, dc_rfwb_addr, dc_load  in  1/AW/1  destination write enable, destination address, instruction is a load.
REQ-011 sel_a, sel_b  out  2 each  registered operand select: 0=RF, 1=IMM (B only), 2=EX_FORW, 3=WB_FORW.
REQ-012 ex_rfwb_en, ex_rfwb_addr  out  1/AW  destination tracked in EX.
REQ-013 load_stall  out  1  load-use hazard; fetch re-presents the same dc_* next cycle.

Function
REQ-014 ID tracking regs (id_en, id_addr, id_ld) SHALL load dc_rfwb_en/dc_rfwb_addr/dc_load at an edge with !id_freeze && !load_stall.
REQ-015 At an edge with !id_freeze && load_stall, ID regs SHALL take a bubble (id_en=0, id_ld=0) and sel_a/sel_b SHALL become 0.
REQ-016 EX regs SHALL load ID regs at an edge with !ex_freeze && !id_freeze, and load a bubble (ex_rfwb_en=0) at an edge with !ex_freeze && id_freeze.
REQ-017 EX regs SHALL hold while ex_freeze; ID regs and sel_a/sel_b SHALL hold while id_freeze.
REQ-018 Match X = Y SHALL require source enable, producer enable, equal address, and address != 0; r0 is never forwarded.
REQ-019 Next sel_a: 2 if dc_rfa_addr matches ID regs; else 3 if it matches EX regs; else 0. EX_FORW has priority when both match.
REQ-020 Next sel_b: 1 if dc_imm (overrides all matches); else same rule as sel_a using dc_rfb_addr.
REQ-021 sel_a/sel_b SHALL update at an edge with !id_freeze && !load_stall; latency 1 cycle from dc_* to sel.
REQ-022 load_stall SHALL be combinational: id_ld && (dc_rfa matches ID regs || (!dc_imm && dc_rfb matches ID regs)).
REQ-023 After one stall bubble the load sits in EX, so the re-presented instruction selects WB_FORW (3) and load_stall deasserts.
REQ-024 flushpipe at an edge (not rst) SHALL clear id_en, id_ld, ex_rfwb_en and set sel_a=sel_b=0, regardless of freezes.
REQ-025 Priority: rst > flushpipe > freeze > normal update.

Reset
REQ-026 While rst is sampled high: sel_a=0, sel_b=0, ex_rfwb_en=0, ex_rfwb_addr=0, and all ID regs=0. load_stall SHALL therefore read 0.
REQ-027 rst mid-stall SHALL drop load_stall on the next cycle and discard all tracked producers.

Configuration
REQ-028 Macro OR1200_FWDCTRL_LOAD_STALL_EN defined: REQ-015/022/023 apply.
REQ-029 Macro OR1200_FWDCTRL_LOAD_STALL_EN undefined: load_stall is tied 0, dc_load and id_ld are ignored, and loads forward like any producer (EX_FORW).

Verification
REQ-030 Back-to-back: add r3 (dest r3) then sub using rfa=r3 with no freeze -> sel_a=2 one cycle after the sub is presented; an unrelated op two slots later using r3 -> sel_a=3.
REQ-031 Double match: r5 in both EX and ID, dc_rfa=r5 -> sel_a=2. dc_rfa=r0 with r0 producers -> sel_a=0.
REQ-032 Immediate: dc_imm=1, dc_rfb=r4 matching ID -> sel_b=1.
REQ-033 Load-use (macro on): lwz r7 in ID, dc_rfa=r7 -> load_stall=1, next sel_a=0, ID bubble. Re-presented -> load_stall=0, sel_a=3. Macro off -> load_stall=0, sel_a=2.
REQ-034 Freeze: id_freeze=1, ex_freeze=0 for 2 cycles -> sel held, EX bubble (ex_rfwb_en=0). ex_freeze=1 -> EX regs held.
REQ-035 flushpipe or rst asserted during load_stall -> next cycle sel_a=sel_b=0, ex_rfwb_en=0, load_stall=0.
